// File: rtl/conv_pkg.sv
// Shared convolution definitions: result-frame geometry and the result buffer state encoding.
// Used by the convolution engine, the result buffer and the display front-end.
`timescale 1ns/1ps
package conv_pkg;

    localparam int CONV_ROWS  = 8;
    localparam int CONV_COLS  = 10;
    localparam int CONV_DEPTH = CONV_ROWS * CONV_COLS;
    localparam int CONV_DW    = 16;
    localparam int CONV_AW    = 7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_READY = 2'd2
    } buf_state_e;

    // row*10 + col as shift-add so no multiplier is inferred
    function automatic logic [CONV_AW-1:0] conv_rc_addr(input logic [2:0] row, input logic [3:0] col);
        conv_rc_addr = {1'b0, row, 3'b000} + {3'b000, row, 1'b0} + {3'b000, col};
    endfunction

endpackage

// File: rtl/conv_result_ram.sv
// Simple dual-port result RAM: synchronous write, registered synchronous read.
// A same-address read and write in one cycle returns the previously stored word.
`timescale 1ns/1ps
module conv_result_ram
    import conv_pkg::*;
#(
    parameter int DEPTH = CONV_DEPTH,
    parameter int DW    = CONV_DW,
    parameter int AW    = CONV_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Storage array and read register; no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/conv_result_buffer.sv
// Captures one convolution result frame into RAM, tracks fill level, signed min/max and
// error flags, and serves (row, col) random reads with a fixed one-cycle latency.
`timescale 1ns/1ps
module conv_result_buffer
    import conv_pkg::*;
#(
    parameter int ROWS = CONV_ROWS,
    parameter int COLS = CONV_COLS,
    parameter int DW   = CONV_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_done,
    input  logic          rd_req,
    input  logic [2:0]    rd_row,
    input  logic [3:0]    rd_col,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [6:0]    count,
    output logic          ready,
    output logic          overflow,
    output logic          short_frame,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] min_val
);

    localparam int         DEPTH   = ROWS * COLS;
    localparam logic [6:0] DEPTH_C = 7'(DEPTH);
    localparam logic [3:0] COLS_C  = 4'(COLS);

    buf_state_e    state_r;
    logic [6:0]    count_r;
    logic          ready_r;
    logic          overflow_r;
    logic          short_frame_r;
    logic [DW-1:0] max_r;
    logic [DW-1:0] min_r;
    logic          rd_valid_r;
    logic          rd_oob_r;

    logic          accept_s;
    logic          drop_s;
    logic          done_s;
    logic [6:0]    count_next_s;
    logic [6:0]    rd_addr_s;
    logic          rd_oob_s;
    logic          ram_re_s;
    logic [DW-1:0] ram_q_s;

    // Classify the incoming sample; clear wins over any stream event in the same cycle.
    always_comb begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
        if (in_valid && !clear) begin
            if ((state_r != S_READY) && (count_r < DEPTH_C)) begin
                accept_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
        count_next_s = accept_s ? (count_r + 7'd1) : count_r;
    end

    assign done_s = in_done && !clear;

    // rd_row is 3 bits so every row value is in range; only the column can overrun.
    assign rd_addr_s = conv_rc_addr(rd_row, rd_col);
    assign rd_oob_s  = (rd_col >= COLS_C);
    assign ram_re_s  = rd_req && !rd_oob_s;

    // Frame state, fill count, sticky flags and running signed min/max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_EMPTY;
            count_r       <= 7'd0;
            ready_r       <= 1'b0;
            overflow_r    <= 1'b0;
            short_frame_r <= 1'b0;
            max_r         <= '0;
            min_r         <= '0;
        end else if (clear) begin
            state_r       <= S_EMPTY;
            count_r       <= 7'd0;
            ready_r       <= 1'b0;
            overflow_r    <= 1'b0;
            short_frame_r <= 1'b0;
            max_r         <= '0;
            min_r         <= '0;
        end else begin
            count_r <= count_next_s;
            if (accept_s) begin
                if (count_r == 7'd0) begin
                    max_r <= in_data;
                    min_r <= in_data;
                end else begin
                    if ($signed(in_data) > $signed(max_r)) max_r <= in_data;
                    if ($signed(in_data) < $signed(min_r)) min_r <= in_data;
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                S_EMPTY: if (accept_s) state_r <= S_FILL;
                S_FILL:  state_r <= S_FILL;
                S_READY: state_r <= S_READY;
                default: state_r <= S_EMPTY;
            endcase
            // Done is judged after this cycle's sample has been counted.
            if (done_s) begin
                state_r <= S_READY;
                ready_r <= 1'b1;
                if (count_next_s != DEPTH_C) begin
                    short_frame_r <= 1'b1;
                end
            end
        end
    end

    // Read response pipeline, aligned with the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_oob_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd_req;
            rd_oob_r   <= rd_req && rd_oob_s;
        end
    end

    conv_result_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (CONV_AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept_s),
        .waddr (count_r),
        .wdata (in_data),
        .re    (ram_re_s),
        .raddr (rd_addr_s),
        .rdata (ram_q_s)
    );

    assign rd_data     = (rd_valid_r && !rd_oob_r) ? ram_q_s : '0;
    assign rd_valid    = rd_valid_r;
    assign count       = count_r;
    assign ready       = ready_r;
    assign overflow    = overflow_r;
    assign short_frame = short_frame_r;
    assign max_val     = max_r;
    assign min_val     = min_r;

endmodule
